// File: rtl/fsm_pkg.sv
// Shared definitions for the IDLE/INIT/STRT control FSM and its passive monitor.
`timescale 1ns/1ps
package fsm_pkg;

  // One-hot encodings of the controlled FSM; the FSM itself uses these too.
  localparam int SIZE = 3;
  localparam logic [SIZE-1:0] IDLE = 3'b001;
  localparam logic [SIZE-1:0] INIT = 3'b010;
  localparam logic [SIZE-1:0] STRT = 3'b100;

  // Monitor's own tracking state.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

  // Fault classification reported on err_code_o.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TRANS   = 2'b10;

  // A state value is legal only when it is exactly one of the three encodings.
  function automatic logic is_legal(input logic [SIZE-1:0] s);
    return (s == IDLE) || (s == INIT) || (s == STRT);
  endfunction

endpackage

// File: rtl/fsm_next_state.sv
// Pure combinational next-state rule of the control FSM, shared by the FSM
// and by the monitor so that the model and the design cannot drift apart.
`timescale 1ns/1ps
module fsm_next_state
  import fsm_pkg::*;
(
  input  logic [SIZE-1:0] state_i,
  input  logic            enable_i,
  input  logic            reset_i,
  output logic [SIZE-1:0] next_o
);

  // Reset dominates enable; with enable low the FSM holds; any corrupted
  // value is steered back into INIT when enabled.
  always_comb begin
    next_o = state_i;
    if (reset_i) begin
      next_o = IDLE;
    end else if (enable_i) begin
      case (state_i)
        IDLE:    next_o = INIT;
        INIT:    next_o = STRT;
        STRT:    next_o = STRT;
        default: next_o = INIT;
      endcase
    end
  end

endmodule

// File: rtl/fsm_state_monitor.sv
// Passive checker for the IDLE/INIT/STRT FSM: shadows the FSM from the
// previous cycle's samples, flags illegal encodings and wrong transitions,
// reports entry to STRT and counts STRT residency and state changes.
`timescale 1ns/1ps
module fsm_state_monitor
  import fsm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic [SIZE-1:0]  state_i,
  input  logic             tgt_reset_i,
  input  logic             tgt_enable_i,
  input  logic             clear_i,
  output logic             synced_o,
  output logic             started_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [SIZE-1:0]  err_exp_o,
  output logic [SIZE-1:0]  err_obs_o,
  output logic [CNT_W-1:0] strt_cnt_o,
  output logic [CNT_W-1:0] trans_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mon_state_e       mon_state_q, mon_state_d;
  logic [SIZE-1:0]  prev_state_q, prev_state_d;
  logic             prev_en_q, prev_en_d;
  logic             prev_rst_q, prev_rst_d;
  logic             started_q, started_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [SIZE-1:0]  err_exp_q, err_exp_d;
  logic [SIZE-1:0]  err_obs_q, err_obs_d;
  logic [CNT_W-1:0] strt_cnt_q, strt_cnt_d;
  logic [CNT_W-1:0] trans_cnt_q, trans_cnt_d;

  logic [SIZE-1:0]  expected;
  logic             cur_legal;
  logic             prev_legal;

  // What the FSM should hold now, given what it held and saw last cycle.
  fsm_next_state u_next_state (
    .state_i  (prev_state_q),
    .enable_i (prev_en_q),
    .reset_i  (prev_rst_q),
    .next_o   (expected)
  );

  assign cur_legal  = is_legal(state_i);
  assign prev_legal = is_legal(prev_state_q);

  // Samples of the FSM's inputs and state are taken on every edge regardless
  // of monitor state, so the model is primed before tracking starts.
  always_comb begin
    prev_state_d = state_i;
    prev_en_d    = tgt_enable_i;
    prev_rst_d   = tgt_reset_i;
  end

  // Monitor next-state, fault capture and counter update; clear beats any
  // fault that would be recorded on the same edge.
  always_comb begin
    mon_state_d = mon_state_q;
    started_d   = 1'b0;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_exp_d   = err_exp_q;
    err_obs_d   = err_obs_q;
    strt_cnt_d  = strt_cnt_q;
    trans_cnt_d = trans_cnt_q;

    unique case (mon_state_q)
      SYNC: begin
        strt_cnt_d  = '0;
        trans_cnt_d = '0;
        if (!clear_i && cur_legal && prev_legal) begin
          mon_state_d = TRACK;
        end
      end

      TRACK: begin
        if (clear_i) begin
          mon_state_d = SYNC;
          strt_cnt_d  = '0;
          trans_cnt_d = '0;
        end else if (!cur_legal) begin
          mon_state_d = FAULT;
          err_d       = 1'b1;
          err_code_d  = ERR_ILLEGAL;
          err_exp_d   = expected;
          err_obs_d   = state_i;
        end else if (state_i != expected) begin
          mon_state_d = FAULT;
          err_d       = 1'b1;
          err_code_d  = ERR_TRANS;
          err_exp_d   = expected;
          err_obs_d   = state_i;
        end else begin
          started_d = (state_i == STRT) && (prev_state_q != STRT);
          if (state_i == STRT) begin
            strt_cnt_d = (strt_cnt_q == CNT_MAX) ? strt_cnt_q : strt_cnt_q + CNT_W'(1);
          end else begin
            strt_cnt_d = '0;
          end
          if (state_i != prev_state_q) begin
            trans_cnt_d = trans_cnt_q + CNT_W'(1);
          end
        end
      end

      FAULT: begin
        if (clear_i) begin
          mon_state_d = SYNC;
          err_d       = 1'b0;
          err_code_d  = ERR_NONE;
          err_exp_d   = '0;
          err_obs_d   = '0;
          strt_cnt_d  = '0;
          trans_cnt_d = '0;
        end
      end

      default: begin
        mon_state_d = SYNC;
      end
    endcase
  end

  // All monitor state and outputs are registered; reset_n_i clears at once.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mon_state_q  <= SYNC;
      prev_state_q <= '0;
      prev_en_q    <= 1'b0;
      prev_rst_q   <= 1'b0;
      started_q    <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_exp_q    <= '0;
      err_obs_q    <= '0;
      strt_cnt_q   <= '0;
      trans_cnt_q  <= '0;
    end else begin
      mon_state_q  <= mon_state_d;
      prev_state_q <= prev_state_d;
      prev_en_q    <= prev_en_d;
      prev_rst_q   <= prev_rst_d;
      started_q    <= started_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_exp_q    <= err_exp_d;
      err_obs_q    <= err_obs_d;
      strt_cnt_q   <= strt_cnt_d;
      trans_cnt_q  <= trans_cnt_d;
    end
  end

  assign synced_o    = (mon_state_q == TRACK);
  assign started_o   = started_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign err_exp_o   = err_exp_q;
  assign err_obs_o   = err_obs_q;
  assign strt_cnt_o  = strt_cnt_q;
  assign trans_cnt_o = trans_cnt_q;

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Self-checking bench for fsm_state_monitor: a hand-derived vector table,
// directed corner-case sequences and a randomized run against a behavioural
// model of the monitor's rules.
`timescale 1ns/1ps
module tb_fsm_state_monitor;
  import fsm_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock;
  logic          reset_n;
  logic [2:0]    state_i;
  logic          tgt_reset;
  logic          tgt_enable;
  logic          clear;
  logic          synced_o;
  logic          started_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic [2:0]    err_exp_o;
  logic [2:0]    err_obs_o;
  logic [CW-1:0] strt_cnt_o;
  logic [CW-1:0] trans_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: mode 0 = waiting for sync, 1 = tracking, 2 = faulted.
  int         m_mode;
  logic [2:0] m_prev_state;
  logic       m_prev_en;
  logic       m_prev_rst;
  logic       m_started;
  logic       m_err;
  int         m_code;
  logic [2:0] m_exp;
  logic [2:0] m_obs;
  int         m_strt;
  int         m_trans;

  fsm_state_monitor #(.CNT_W(CW)) dut (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .state_i      (state_i),
    .tgt_reset_i  (tgt_reset),
    .tgt_enable_i (tgt_enable),
    .clear_i      (clear),
    .synced_o     (synced_o),
    .started_o    (started_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o),
    .err_exp_o    (err_exp_o),
    .err_obs_o    (err_obs_o),
    .strt_cnt_o   (strt_cnt_o),
    .trans_cnt_o  (trans_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Controlled FSM's rule: states advance IDLE->INIT->STRT and stick in STRT.
  function automatic logic [2:0] fsm_rule(input logic [2:0] s, input logic r, input logic e);
    if (r) return IDLE;
    if (!e) return s;
    return (s == INIT || s == STRT) ? STRT : INIT;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev_state = '0; m_prev_en = 0; m_prev_rst = 0;
    m_started = 0; m_err = 0; m_code = 0; m_exp = '0; m_obs = '0;
    m_strt = 0; m_trans = 0;
  endtask

  task automatic model_clear();
    m_mode = 0; m_err = 0; m_code = 0; m_exp = '0; m_obs = '0;
    m_strt = 0; m_trans = 0;
  endtask

  task automatic model_edge(input logic [2:0] s, input logic r, input logic e, input logic c);
    logic [2:0] want;
    want = fsm_rule(m_prev_state, m_prev_rst, m_prev_en);
    m_started = 0;
    if (m_mode == 0) begin
      if (c) model_clear();
      else if ($onehot(s) && $onehot(m_prev_state)) m_mode = 1;
    end else if (m_mode == 1) begin
      if (c) model_clear();
      else if (!$onehot(s) || s != want) begin
        m_mode = 2; m_err = 1; m_code = $onehot(s) ? 2 : 1;
        m_exp = want; m_obs = s;
      end else begin
        m_started = (s == STRT) && (m_prev_state != STRT);
        m_strt = (s == STRT) ? ((m_strt + 1 > CMAX) ? CMAX : m_strt + 1) : 0;
        if (s != m_prev_state) m_trans = (m_trans + 1) % (CMAX + 1);
      end
    end else begin
      if (c) model_clear();
    end
    m_prev_state = s; m_prev_en = e; m_prev_rst = r;
  endtask

  // The model observes the same stimulus the DUT sees, on the same edges.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_edge(state_i, tgt_reset, tgt_enable, clear);
  end

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check_val("synced_o",    int'(synced_o),    m_mode == 1 ? 1 : 0);
    check_val("started_o",   int'(started_o),   int'(m_started));
    check_val("err_o",       int'(err_o),       int'(m_err));
    check_val("err_code_o",  int'(err_code_o),  m_code);
    check_val("err_exp_o",   int'(err_exp_o),   int'(m_exp));
    check_val("err_obs_o",   int'(err_obs_o),   int'(m_obs));
    check_val("strt_cnt_o",  int'(strt_cnt_o),  m_strt);
    check_val("trans_cnt_o", int'(trans_cnt_o), m_trans);
  endtask

  task automatic applyStimulus(input logic [2:0] s, input logic r, input logic e, input logic c);
    @(negedge clock);
    state_i = s; tgt_reset = r; tgt_enable = e; clear = c;
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  typedef struct {
    logic [2:0] st;
    logic       rst;
    logic       en;
    logic       clr;
    int         err;
    int         code;
    int         exp_s;
    int         obs_s;
    int         synced;
    int         started;
    int         strt;
    int         trans;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // st, rst, en, clr | err, code, exp, obs, synced, started, strt, trans
    tbl[0]  = '{3'b001, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{3'b001, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{3'b010, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[3]  = '{3'b100, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, 1, 1, 2};
    tbl[4]  = '{3'b100, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 2, 2};
    tbl[5]  = '{3'b100, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 3, 2};
    tbl[6]  = '{3'b001, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 0, 3};
    tbl[7]  = '{3'b010, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 0, 4};
    tbl[8]  = '{3'b001, 1'b0, 1'b1, 1'b0, 1, 2, 4, 1, 0, 0, 0, 4};
    tbl[9]  = '{3'b001, 1'b0, 1'b1, 1'b0, 1, 2, 4, 1, 0, 0, 0, 4};
    tbl[10] = '{3'b001, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{3'b001, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{3'b010, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 0, 1};

    reset_n = 1'b0; state_i = '0; tgt_reset = 0; tgt_enable = 0; clear = 0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput();
    @(negedge clock);
    reset_n = 1'b1;

    // Power-up, reset dominance without fault, wrong transition, clear and resync.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].st, tbl[i].rst, tbl[i].en, tbl[i].clr);
      check_val($sformatf("tbl%0d.err", i),     int'(err_o),       tbl[i].err);
      check_val($sformatf("tbl%0d.code", i),    int'(err_code_o),  tbl[i].code);
      check_val($sformatf("tbl%0d.exp", i),     int'(err_exp_o),   tbl[i].exp_s);
      check_val($sformatf("tbl%0d.obs", i),     int'(err_obs_o),   tbl[i].obs_s);
      check_val($sformatf("tbl%0d.synced", i),  int'(synced_o),    tbl[i].synced);
      check_val($sformatf("tbl%0d.started", i), int'(started_o),   tbl[i].started);
      check_val($sformatf("tbl%0d.strt", i),    int'(strt_cnt_o),  tbl[i].strt);
      check_val($sformatf("tbl%0d.trans", i),   int'(trans_cnt_o), tbl[i].trans);
    end

    // Residency saturation over 20 STRT cycles, then one IDLE sample.
    for (int i = 0; i < 20; i++) applyStimulus(STRT, 0, 1, 0);
    check_val("sat.strt", int'(strt_cnt_o), CMAX);
    applyStimulus(STRT, 1, 1, 0);
    check_val("sat.hold", int'(strt_cnt_o), CMAX);
    applyStimulus(IDLE, 0, 1, 0);
    check_val("sat.clear", int'(strt_cnt_o), 0);
    check_val("sat.err", int'(err_o), 0);

    // Reset dominance: after tgt_reset with enable, staying in STRT is wrong.
    applyStimulus(INIT, 0, 1, 0);
    applyStimulus(STRT, 0, 1, 0);
    applyStimulus(STRT, 1, 1, 0);
    applyStimulus(STRT, 0, 1, 0);
    check_val("dom.code", int'(err_code_o), 2);
    check_val("dom.exp",  int'(err_exp_o),  int'(IDLE));
    check_val("dom.obs",  int'(err_obs_o),  int'(STRT));
    applyStimulus(STRT, 0, 0, 1);
    check_val("dom.clr", int'(err_o), 0);

    // Illegal encoding while tracking, sticky over 10 cycles, then clear.
    applyStimulus(STRT, 0, 0, 0);
    applyStimulus(STRT, 0, 0, 0);
    check_val("ill.synced", int'(synced_o), 1);
    applyStimulus(3'b011, 0, 0, 0);
    check_val("ill.code", int'(err_code_o), 1);
    check_val("ill.obs",  int'(err_obs_o),  3);
    check_val("ill.exp",  int'(err_exp_o),  int'(STRT));
    for (int i = 0; i < 10; i++) applyStimulus(STRT, 0, 0, 0);
    check_val("ill.sticky", int'(err_o), 1);
    applyStimulus(STRT, 0, 0, 1);
    check_val("ill.clr.err", int'(err_o), 0);
    check_val("ill.clr.syn", int'(synced_o), 0);
    applyStimulus(STRT, 0, 0, 0);
    check_val("ill.resync", int'(synced_o), 1);

    // Clear in the same cycle as a would-be fault: clear wins.
    applyStimulus(3'b110, 0, 0, 1);
    check_val("clrwin.err", int'(err_o), 0);
    check_val("clrwin.syn", int'(synced_o), 0);
    applyStimulus(STRT, 0, 0, 0);
    applyStimulus(STRT, 0, 0, 0);
    applyStimulus(STRT, 0, 0, 0);

    // Asynchronous reset between edges while faulted.
    applyStimulus(3'b111, 0, 0, 0);
    check_val("arst.pre", int'(err_o), 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput();
    check_val("arst.err", int'(err_o), 0);
    check_val("arst.cnt", int'(trans_cnt_o), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Randomized run: a well-behaved FSM with occasional corruption and clears.
    begin
      logic [2:0] fsm_st;
      logic [2:0] drive;
      logic       r, e, c;
      fsm_st = IDLE;
      for (int i = 0; i < 800; i++) begin
        r = ($urandom_range(0, 9) == 0);
        e = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 29) == 0);
        drive = fsm_st;
        if ($urandom_range(0, 39) == 0) drive = 3'($urandom_range(0, 7));
        applyStimulus(drive, r, e, c);
        fsm_st = fsm_rule(fsm_st, r, e);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_state_monitor.md
Name: fsm_state_monitor

Overview:
- Passive checker for the IDLE/INIT/STRT one-hot control FSM. It observes the FSM's state bus together with the FSM's synchronous reset and enable on the same clock.
- Keeps a shadow model of the FSM, flags illegal encodings and wrong transitions, reports first entry to STRT, and counts residency in STRT.
- Sits beside the FSM in testbenches and in debug builds. It never drives the FSM.

Parameters:
- SIZE, 3, state bus width (one-hot).
- IDLE, 3'b001, idle encoding.
- INIT, 3'b010, init encoding.
- STRT, 3'b100, started encoding.
- CNT_W, 8, width of the STRT residency counter and the transition counter.

Ports:
- clock_i  input  1  system clock; all sampling on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset of the monitor.
- state_i  input  SIZE  observed FSM state register.
- tgt_reset_i  input  1  the FSM's synchronous active-high reset, as seen by the FSM.
- tgt_enable_i  input  1  the FSM's enable, as seen by the FSM.
- clear_i  input  1  clears the fault and restarts synchronisation; sampled on the rising edge.
- synced_o  output  1  high while the monitor is in TRACK.
- started_o  output  1  one-cycle pulse when STRT is entered.
- err_o  output  1  sticky fault flag.
- err_code_o  output  2  00 none, 01 illegal encoding, 10 wrong transition.
- err_exp_o  output  SIZE  expected state captured at the fault.
- err_obs_o  output  SIZE  observed state captured at the fault.
- strt_cnt_o  output  CNT_W  consecutive cycles in STRT, saturating.
- trans_cnt_o  output  CNT_W  count of state changes observed in TRACK, wrapping.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - Monitor state goes to SYNC.
  - All outputs 0; err_exp_o and err_obs_o are 0.
  - Internal samples prev_state, prev_en and prev_rst are 0.
- Every edge registers prev_state <= state_i, prev_en <= tgt_enable_i, prev_rst <= tgt_reset_i.
- Expected state, combinational, from the registered samples:
  - prev_rst=1 -> IDLE.
  - else prev_en=0 -> prev_state.
  - else IDLE->INIT, INIT->STRT, STRT->STRT, any other value->INIT.
- Legal encoding means state_i is exactly IDLE, INIT or STRT.
- Monitor states:
  - SYNC:
    - No checks; counters are held at 0.
    - Goes to TRACK on the first edge where state_i is legal and the previous sample was also legal.
    - This ensures the expected-state model is valid from the first checked cycle.
  - TRACK, evaluated each edge:
    - state_i illegal -> FAULT, err_code_o=01.
    - else state_i != expected -> FAULT, err_code_o=10.
    - else stay in TRACK.
    - On any FAULT entry: err_o=1; err_exp_o and err_obs_o capture the expected and observed values at that edge.
    - The illegal-encoding check has priority over the transition check.
  - FAULT:
    - err_o and all captured fields hold.
    - Counters freeze. synced_o=0.
    - clear_i=1 -> SYNC, and err_o, err_code_o, err_exp_o and err_obs_o clear to 0.
  - clear_i in SYNC or TRACK:
    - Returns to SYNC.
    - Zeroes strt_cnt_o and trans_cnt_o.
- Latency:
  - All outputs are registered.
  - A fault on the state_i value sampled at edge k is visible on err_o immediately after edge k.
- started_o:
  - Pulses high for one cycle after edge k when, in TRACK with no fault at k, state_i==STRT and prev_state!=STRT.
  - It is not asserted for a STRT value seen in SYNC.
- strt_cnt_o:
  - In TRACK, increments on each edge with state_i==STRT.
  - Saturates at 2^CNT_W-1.
  - Resets to 0 on any TRACK edge with state_i!=STRT.
- trans_cnt_o:
  - Increments in TRACK when state_i!=prev_state and no fault occurs.
  - Wraps modulo 2^CNT_W.
- Simultaneous events:
  - tgt_reset_i and tgt_enable_i both high -> expected IDLE (reset dominates, matching the FSM).
  - clear_i in the same cycle as a would-be fault in TRACK -> clear wins; no fault is recorded.
- reset_n_i asserted mid-operation overrides everything immediately and returns the monitor to SYNC with all outputs at 0.

Decomposition:
- Shared package fsm_pkg holds:
  - SIZE and the IDLE/INIT/STRT encodings, also used by the FSM itself.
  - Monitor state encodings SYNC/TRACK/FAULT.
  - Error code constants ERR_NONE, ERR_ILLEGAL, ERR_TRANS.
- One sub-module: fsm_next_state, a pure combinational expected-next-state function.
  - Inputs: state, enable, reset. Output: next state.
  - Shared with the FSM so model and design cannot diverge.

Test Plan:
1. Power-up: reset_n_i low 2 cycles; release; tgt_reset_i=1 for 1 cycle, then tgt_enable_i=1 -> state_i runs 001,010,100; synced_o=1 from the second legal sample; started_o pulses exactly once on the 100 sample; trans_cnt_o=2.
2. Residency and saturation: CNT_W=4, hold STRT for 20 cycles -> strt_cnt_o counts 1..15 and stays at 15; one IDLE sample via tgt_reset_i -> strt_cnt_o=0.
3. Illegal encoding: in TRACK, force state_i=3'b011 -> err_o=1, err_code_o=01, err_obs_o=011, err_exp_o equals the model value; err_o holds across 10 cycles; clear_i=1 -> err_o=0, synced_o=0, then resync on two legal samples.
4. Wrong transition: enable=1 with state INIT, force state_i=IDLE next cycle -> err_code_o=10, err_exp_o=100, err_obs_o=001.
5. Reset dominance: tgt_reset_i=1 and tgt_enable_i=1 while in STRT, next state_i=001 -> no fault; if state_i=100 instead -> err_code_o=10, err_exp_o=001.
6. Asynchronous reset mid-FAULT: assert reset_n_i between clock edges -> err_o, counters and synced_o go to 0 without waiting for a clock edge.
